// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-entry decode/issue register feeding the ALU with load-use stall
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_ra1,
    output logic [2:0]  rf_ra2,
    input  logic [15:0] rf_rd1,
    input  logic [15:0] rf_rd2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] op1,
    output logic [15:0] op2,
    output logic [2:0]  cmd,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] store_data,
    output logic        is_branch,
    output logic        illegal,
    output logic [7:0]  stall_cnt
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_EQ  = 3'b111;

    // Instruction fields
    logic [3:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [2:0]  funct;
    logic [15:0] imm;

    assign op     = instr[15:12];
    assign rs     = instr[11:9];
    assign rt     = instr[8:6];
    assign rd     = instr[5:3];
    assign funct  = instr[2:0];
    assign imm    = {{10{instr[5]}}, instr[5:0]};

    // Register-file addresses go out combinationally so read data lands in the accept cycle
    assign rf_ra1 = rs;
    assign rf_ra2 = rt;

    // Decoded entry, presented to the output register on accept
    logic [15:0] d_op1;
    logic [15:0] d_op2;
    logic [2:0]  d_cmd;
    logic        d_wb_en;
    logic [2:0]  d_wb_addr;
    logic        d_mem_rd;
    logic        d_mem_wr;
    logic [15:0] d_store_data;
    logic        d_is_branch;
    logic        d_illegal;

    // Instruction decode; unknown opcodes become inert entries flagged illegal
    always_comb begin
        d_op1        = 16'h0000;
        d_op2        = 16'h0000;
        d_cmd        = CMD_ADD;
        d_wb_en      = 1'b0;
        d_wb_addr    = 3'b000;
        d_mem_rd     = 1'b0;
        d_mem_wr     = 1'b0;
        d_store_data = 16'h0000;
        d_is_branch  = 1'b0;
        d_illegal    = 1'b0;
        case (op)
            OP_R: begin
                d_op1     = rf_rd1;
                d_op2     = rf_rd2;
                d_cmd     = funct;
                d_wb_en   = 1'b1;
                d_wb_addr = rd;
            end
            OP_ADDI: begin
                d_op1     = rf_rd1;
                d_op2     = imm;
                d_wb_en   = 1'b1;
                d_wb_addr = rt;
            end
            OP_BEQ: begin
                d_op1       = rf_rd1;
                d_op2       = rf_rd2;
                d_cmd       = CMD_EQ;
                d_is_branch = 1'b1;
            end
            OP_LW: begin
                d_op1     = rf_rd1;
                d_op2     = imm;
                d_mem_rd  = 1'b1;
                d_wb_en   = 1'b1;
                d_wb_addr = rt;
            end
            OP_SW: begin
                d_op1        = rf_rd1;
                d_op2        = imm;
                d_mem_wr     = 1'b1;
                d_store_data = rf_rd2;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the held load writes a register the incoming instruction reads.
    // rt is a source only for R-type, BEQ and SW.
    logic rt_is_src;
    logic hazard;
    logic accept;

    assign rt_is_src = (op == OP_R) || (op == OP_BEQ) || (op == OP_SW);
    assign hazard    = out_valid && mem_rd &&
                       ((wb_addr == rs) || ((wb_addr == rt) && rt_is_src));
    assign in_ready  = (!out_valid || out_ready) && !hazard && !flush;
    assign accept    = in_valid && in_ready;

    // Entry valid flag: flush wins, then accept, then drain to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Entry payload: loads only on accept so it holds stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1        <= 16'h0000;
            op2        <= 16'h0000;
            cmd        <= 3'b000;
            wb_en      <= 1'b0;
            wb_addr    <= 3'b000;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            store_data <= 16'h0000;
            is_branch  <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            op1        <= d_op1;
            op2        <= d_op2;
            cmd        <= d_cmd;
            wb_en      <= d_wb_en;
            wb_addr    <= d_wb_addr;
            mem_rd     <= d_mem_rd;
            mem_wr     <= d_mem_wr;
            store_data <= d_store_data;
            is_branch  <= d_is_branch;
            illegal    <= d_illegal;
        end
    end

    // Saturating bubble counter; a flushed cycle is not a load-use bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 8'h00;
        end else if (hazard && out_ready && !flush && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue against a decode/issue reference model
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  cmd;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] store_data;
    logic        is_branch;
    logic        illegal;
    logic [7:0]  stall_cnt;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op1        (op1),
        .op2        (op2),
        .cmd        (cmd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .store_data (store_data),
        .is_branch  (is_branch),
        .illegal    (illegal),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  cmd;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [15:0] sd;
        logic        br;
        logic        ill;
    } ent_t;

    logic [15:0] rf [8];
    ent_t        m;
    int          m_stall;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each opcode, written from the instruction-set table
    function automatic ent_t ref_decode(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
        ent_t e;
        int   op;
        int   sx;
        e    = '0;
        e.v  = 1'b1;
        op   = int'(i[15:12]);
        sx   = int'(i[5:0]);
        if (sx >= 32) sx = sx - 64;
        case (op)
            0: begin e.op1 = a; e.op2 = b;          e.cmd = i[2:0]; e.wb_en = 1; e.wb_addr = i[5:3]; end
            1: begin e.op1 = a; e.op2 = 16'(sx);    e.cmd = 3'd0;   e.wb_en = 1; e.wb_addr = i[8:6]; end
            2: begin e.op1 = a; e.op2 = b;          e.cmd = 3'd7;   e.br = 1; end
            3: begin e.op1 = a; e.op2 = 16'(sx);    e.cmd = 3'd0;   e.mem_rd = 1; e.wb_en = 1; e.wb_addr = i[8:6]; end
            4: begin e.op1 = a; e.op2 = 16'(sx);    e.cmd = 3'd0;   e.mem_wr = 1; e.sd = b; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, m.v);
        check("stall_cnt", stall_cnt, m_stall);
        if (m.v) begin
            check("op1", op1, m.op1);
            check("op2", op2, m.op2);
            check("cmd", cmd, m.cmd);
            check("wb_en", wb_en, m.wb_en);
            check("mem_rd", mem_rd, m.mem_rd);
            check("mem_wr", mem_wr, m.mem_wr);
            check("is_branch", is_branch, m.br);
            check("illegal", illegal, m.ill);
            if (m.wb_en) check("wb_addr", wb_addr, m.wb_addr);
            if (m.mem_wr) check("store_data", store_data, m.sd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_op1"}, op1, 0);
        check({tag, "_op2"}, op2, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_wb_en"}, wb_en, 0);
        check({tag, "_wb_addr"}, wb_addr, 0);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_store_data"}, store_data, 0);
        check({tag, "_is_branch"}, is_branch, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    // One clock: called at a falling edge with inputs freshly driven
    task automatic cycle();
        bit hz;
        bit rdy;
        bit acc;
        int op;
        #1;
        op  = int'(instr[15:12]);
        hz  = m.v && m.mem_rd &&
              (m.wb_addr == instr[11:9] || (m.wb_addr == instr[8:6] && (op == 0 || op == 2 || op == 4)));
        rdy = (!m.v || out_ready) && !hz && !flush;
        acc = in_valid && rdy;
        check("in_ready", in_ready, rdy);
        check("rf_ra1", rf_ra1, instr[11:9]);
        check("rf_ra2", rf_ra2, instr[8:6]);
        @(posedge clk);
        if (hz && out_ready && !flush && m_stall < 255) m_stall++;
        if (flush) m.v = 1'b0;
        else if (acc) m = ref_decode(instr, rf[instr[11:9]], rf[instr[8:6]]);
        else if (out_ready) m.v = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic [15:0] i, input logic iv, input logic ordy, input logic fl);
        instr     = i;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rf_rd1    = rf[i[11:9]];
        rf_rd2    = rf[i[8:6]];
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m       = '0;
        m_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ent_t        held;
        logic [15:0] ri;
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        instr     = 16'h0000;
        rf_rd1    = 16'h0000;
        rf_rd2    = 16'h0000;
        for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);

        // Reset holds every registered output low, even with a valid instruction waiting
        rst_n    = 1'b0;
        instr    = 16'h0A98;
        in_valid = 1'b1;
        m        = '0;
        m_stall  = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n    = 1'b1;

        // R-type add
        rf[5] = 16'd7;
        rf[2] = 16'd9;
        drive(16'h0A98, 1, 1, 0);
        check("radd_op1", op1, 16'd7);
        check("radd_op2", op2, 16'd9);
        check("radd_wb_addr", wb_addr, 3'd3);
        check("radd_valid", out_valid, 1);

        // ADDI with all-ones six-bit immediate
        drive(16'h127F, 1, 1, 0);
        check("addi_op2", op2, 16'hFFFF);
        check("addi_wb_addr", wb_addr, 3'd1);
        check("addi_cmd", cmd, 3'd0);

        // Load-use: LW r2 then R-type reading r2
        drive(16'h3084, 1, 1, 0);
        check("lw_mem_rd", mem_rd, 1);
        drive(16'h0458, 1, 1, 0);
        check("lu_bubble", out_valid, 0);
        check("lu_stall", stall_cnt, 8'd1);
        drive(16'h0458, 1, 1, 0);
        check("lu_issue", out_valid, 1);

        // Backpressure: entry held for three cycles, then next instr accepted
        drive(16'h4A45, 1, 1, 0);
        held = m;
        for (int k = 0; k < 3; k++) begin
            drive(16'h0298, 1, 0, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_op2_hold", op2, held.op2);
            check("bp_sd_hold", store_data, held.sd);
        end
        drive(16'h0298, 1, 1, 0);
        check("bp_release_wb", wb_en, 1);

        // Flush drops the held entry and the incoming instruction
        drive(16'h1045, 1, 0, 1);
        check("flush_valid", out_valid, 0);
        check("flush_stall", stall_cnt, 8'd1);

        // Illegal opcode still issues as an inert entry
        drive(16'hF123, 1, 1, 0);
        check("ill_flag", illegal, 1);
        check("ill_wb_en", wb_en, 0);

        // Asynchronous reset mid-cycle clears outputs before any clock edge
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m       = '0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 9) < 8) ri[15:12] = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
            drive(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // Saturation of the bubble counter
        do_reset();
        for (int n = 0; n < 270; n++) begin
            drive(16'h3084, 1, 1, 0);
            drive(16'h0458, 1, 1, 0);
        end
        check("stall_saturated", stall_cnt, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
